// File: rtl/gpio_pattern_sequencer_if.sv
// Wishbone slave bus bundle for the GPIO pattern sequencer register port.
interface gpio_pattern_sequencer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  adr;
  logic [31:0] dat_w;
  logic        ack;
  logic [31:0] dat_r;

  modport master (output cyc, stb, we, adr, dat_w, input  ack, dat_r);
  modport slave  (input  cyc, stb, we, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/gpio_pattern_sequencer.sv
// Wishbone-programmed FIFO of {checkbits, status, dwell} patterns played out on
// user IO, one entry per dwell+1 cycles, with optional looping and a done pulse.
module gpio_pattern_sequencer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb,
  output logic        irq_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_PUSH = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;

  typedef struct packed {
    logic [11:0] dwell;
    logic [3:0]  status;
    logic [15:0] checkbits;
  } entry_t;

  logic [1:0]    state_q, state_d;
  logic          en_q, en_d, loop_q, loop_d, ovf_q, ovf_d, oeb_q, oeb_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [11:0]   dwell_q, dwell_d;
  logic [19:0]   out_q, out_d;
  logic          irq_q, irq_d, ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;

  logic [31:0]   mem_q [DEPTH];
  logic          mem_we_c;
  logic [31:0]   mem_wdata_c;
  entry_t        head_c;
  logic          pop_c;
  logic [CW-1:0] cnt_after_c;

  logic bus_req_c, wr_ctrl_c, wr_push_c, flush_c, push_ok_c;
  logic unused_adr_c;

  assign head_c       = entry_t'(mem_q[rd_ptr_q]);
  assign bus_req_c    = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr_ctrl_c    = bus_req_c & wbs_we_i & (wbs_adr_i[3:2] == A_CTRL);
  assign wr_push_c    = bus_req_c & wbs_we_i & (wbs_adr_i[3:2] == A_PUSH);
  assign flush_c      = wr_ctrl_c & wbs_dat_i[2];
  // A running loop owns the tail slot, so bus pushes are refused until IDLE.
  assign push_ok_c    = wr_push_c && (count_q != CW'(DEPTH)) && !(loop_q && (state_q != S_IDLE));
  assign unused_adr_c = ^wbs_adr_i[1:0];

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    loop_d      = loop_q;
    ovf_d       = ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dwell_d     = dwell_q;
    out_d       = out_q;
    ack_d       = bus_req_c;
    dat_d       = '0;
    mem_we_c    = 1'b0;
    mem_wdata_c = wbs_dat_i;
    pop_c       = 1'b0;
    cnt_after_c = loop_q ? count_q : (count_q - CW'(1) + CW'(push_ok_c));

    if (bus_req_c && !wbs_we_i) begin
      case (wbs_adr_i[3:2])
        A_CTRL:  dat_d = {30'd0, loop_q, en_q};
        A_STAT:  dat_d = {19'd0, ovf_q, 2'b00, state_q, 3'b000, 5'(count_q)};
        default: dat_d = '0;
      endcase
    end

    if (wr_ctrl_c) begin
      en_d   = wbs_dat_i[0];
      loop_d = wbs_dat_i[1];
      if (wbs_dat_i[3]) ovf_d = 1'b0;
    end
    if (wr_push_c && !push_ok_c) ovf_d = 1'b1;

    case (state_q)
      S_IDLE: if (en_q && (count_q != '0)) state_d = S_LOAD;
      S_LOAD: begin
        if (!en_q || (count_q == '0)) begin
          state_d = S_IDLE;
        end else begin
          pop_c   = 1'b1;
          out_d   = {head_c.status, head_c.checkbits};
          dwell_d = head_c.dwell;
          if (head_c.dwell != '0)      state_d = S_HOLD;
          else if (cnt_after_c != '0)  state_d = S_LOAD;
          else                         state_d = S_DONE;
        end
      end
      S_HOLD: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else begin
          dwell_d = dwell_q - 12'd1;
          if (dwell_q == 12'd1) state_d = (count_q != '0) ? S_LOAD : S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push_ok_c) begin
      mem_we_c    = 1'b1;
      mem_wdata_c = wbs_dat_i;
      wr_ptr_d    = wr_ptr_q + PW'(1);
    end
    // In loop mode the popped head is recycled to the tail on the same edge.
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (loop_q) begin
        mem_we_c    = 1'b1;
        mem_wdata_c = head_c;
        wr_ptr_d    = wr_ptr_q + PW'(1);
      end
    end
    count_d = count_q + CW'(push_ok_c) - CW'(pop_c && !loop_q);

    if (flush_c) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      mem_we_c = 1'b0;
      out_d    = out_q;
      dwell_d  = dwell_q;
    end

    oeb_d = ~en_d;
    irq_d = (state_d == S_DONE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      loop_q   <= 1'b0;
      ovf_q    <= 1'b0;
      oeb_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dwell_q  <= '0;
      out_q    <= '0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      loop_q   <= loop_d;
      ovf_q    <= ovf_d;
      oeb_q    <= oeb_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dwell_q  <= dwell_d;
      out_q    <= out_d;
      irq_q    <= irq_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  // Pattern storage needs no reset; count and pointers define validity.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we_c) mem_q[wr_ptr_q] <= mem_wdata_c;
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;
  assign io_out    = {2'b00, out_q, 16'h0000};
  assign io_oeb    = {2'b11, {20{oeb_q}}, 16'hFFFF};

endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// Self-checking bench: register vector table, directed corner sequences and
// randomized pattern programs checked against a queue-based playback model.
module tb_gpio_pattern_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam logic [3:0] R_CTRL = 4'h0;
  localparam logic [3:0] R_PUSH = 4'h4;
  localparam logic [3:0] R_STAT = 4'h8;
  localparam logic [37:0] OEB_ON  = {2'b11, 20'h00000, 16'hFFFF};
  localparam logic [37:0] OEB_OFF = {38{1'b1}};

  typedef struct packed {
    logic [11:0] dwell;
    logic [3:0]  status;
    logic [15:0] cb;
  } ent_t;

  typedef struct packed {
    logic [3:0]  adr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [37:0] io_out, io_oeb;
  logic        irq_o;

  gpio_pattern_sequencer_if bus ();

  gpio_pattern_sequencer #(.DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(bus.cyc),
    .wbs_stb_i(bus.stb),
    .wbs_we_i (bus.we),
    .wbs_adr_i(bus.adr),
    .wbs_dat_i(bus.dat_w),
    .wbs_ack_o(bus.ack),
    .wbs_dat_o(bus.dat_r),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_fail = 0;
  ent_t  q_model[$];
  logic  m_ovf   = 1'b0;
  logic [19:0] last_io = '0;
  vec_t  vt[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    logic got = 1'b0;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1; bus.adr = a; bus.dat_w = d;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.ack) begin got = 1'b1; break; end
    end
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    chk("wr_ack", 64'(got), 64'd1);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    logic got = 1'b0;
    d = '0;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = a;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.ack) begin got = 1'b1; d = bus.dat_r; break; end
    end
    bus.cyc = 1'b0; bus.stb = 1'b0;
    chk("rd_ack", 64'(got), 64'd1);
    @(posedge clk); #1;
    chk("rd_idle", {31'd0, bus.ack, bus.dat_r}, 64'd0);
  endtask

  task automatic push(input logic [15:0] cb, input logic [3:0] st, input logic [11:0] dw);
    ent_t e;
    e.cb = cb; e.status = st; e.dwell = dw;
    wb_write(R_PUSH, e);
    if (q_model.size() < DEPTH) q_model.push_back(e);
    else m_ovf = 1'b1;
  endtask

  function automatic logic [31:0] stat_exp(input logic [1:0] st);
    return {19'd0, m_ovf, 2'b00, st, 3'b000, 5'(q_model.size())};
  endfunction

  task automatic rd_chk(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(a, d);
    chk(nm, 64'(d), 64'(exp));
  endtask

  // Every entry shows for dwell+1 cycles; irq marks the final cycle of the last one.
  task automatic expect_seq();
    logic [20:0] exp_s[$];
    int n = q_model.size();
    for (int i = 0; i < n; i++)
      for (int d = 0; d <= int'(q_model[i].dwell); d++)
        exp_s.push_back({(i == n - 1) && (d == int'(q_model[i].dwell)),
                         q_model[i].status, q_model[i].cb});
    chk("oeb_en", 64'(io_oeb), 64'(OEB_ON));
    @(posedge clk); #1;
    chk("start_lat", {25'd0, irq_o, io_out}, {25'd0, 1'b0, 2'b00, last_io, 16'h0000});
    if (n > 0) last_io = {q_model[n-1].status, q_model[n-1].cb};
    exp_s.push_back({1'b0, last_io});
    exp_s.push_back({1'b0, last_io});
    foreach (exp_s[k]) begin
      @(posedge clk); #1;
      chk("seq", {25'd0, irq_o, io_out}, {25'd0, exp_s[k][20], 2'b00, exp_s[k][19:0], 16'h0000});
    end
    q_model.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [19:0] ev;
    int k;

    vt[0]  = '{R_CTRL, 1'b0, 32'h0,          32'h0};
    vt[1]  = '{R_STAT, 1'b0, 32'h0,          32'h0};
    vt[2]  = '{4'hC,   1'b0, 32'h0,          32'h0};
    vt[3]  = '{4'hC,   1'b1, 32'hFFFF_FFFF,  32'h0};
    vt[4]  = '{4'hC,   1'b0, 32'h0,          32'h0};
    vt[5]  = '{R_CTRL, 1'b1, 32'h2,          32'h0};
    vt[6]  = '{R_CTRL, 1'b0, 32'h0,          32'h2};
    vt[7]  = '{R_CTRL, 1'b1, 32'hC,          32'h0};
    vt[8]  = '{R_CTRL, 1'b0, 32'h0,          32'h0};
    vt[9]  = '{R_PUSH, 1'b1, 32'h0031_1234,  32'h0};
    vt[10] = '{R_PUSH, 1'b1, 32'h0024_5678,  32'h0};
    vt[11] = '{R_STAT, 1'b0, 32'h0,          32'h2};
    vt[12] = '{R_CTRL, 1'b1, 32'h4,          32'h0};
    vt[13] = '{R_STAT, 1'b0, 32'h0,          32'h0};

    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.adr = '0; bus.dat_w = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_io",  64'(io_out), 64'd0);
    chk("rst_oeb", 64'(io_oeb), 64'(OEB_OFF));
    chk("rst_bus", {30'd0, bus.ack, irq_o, bus.dat_r}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      if (vt[i].we) wb_write(vt[i].adr, vt[i].wd);
      else begin
        wb_read(vt[i].adr, d);
        chk($sformatf("vec%0d", i), 64'(d), 64'(vt[i].exp));
      end
    end

    // Basic two-entry program
    wb_write(R_CTRL, 32'hC);
    push(16'hAB40, 4'hA, 12'd3);
    push(16'h0009, 4'h5, 12'd0);
    wb_write(R_CTRL, 32'h1);
    expect_seq();
    rd_chk("seq_done_stat", R_STAT, stat_exp(2'd0));
    wb_write(R_CTRL, 32'h0);

    // Overflow on a full FIFO, then clear_ovf
    for (int i = 0; i < DEPTH + 1; i++) push(16'(i), 4'(i), 12'd0);
    rd_chk("ovf_stat", R_STAT, stat_exp(2'd0));
    chk("ovf_model", 64'(stat_exp(2'd0)), 64'h1008);
    wb_write(R_CTRL, 32'h8);
    m_ovf = 1'b0;
    rd_chk("ovf_clr", R_STAT, stat_exp(2'd0));
    wb_write(R_CTRL, 32'h4);
    q_model.delete();

    // Flush lands on the same edge as the first LOAD pop
    push(16'h5555, 4'h1, 12'd0);
    push(16'h6666, 4'h2, 12'd0);
    wb_write(R_CTRL, 32'h1);
    @(posedge clk); #1;
    wb_write(R_CTRL, 32'h5);
    q_model.delete();
    chk("flush_io", 64'(io_out), {26'd0, 2'b00, last_io, 16'h0000});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("flush_irq", 64'(irq_o), 64'd0);
    end
    rd_chk("flush_stat", R_STAT, 32'h0);
    wb_write(R_CTRL, 32'h0);

    // Randomized programs against the playback model
    for (int it = 0; it < 20; it++) begin
      wb_write(R_CTRL, 32'hC);
      q_model.delete();
      m_ovf = 1'b0;
      k = $urandom_range(1, DEPTH + 2);
      for (int i = 0; i < k; i++)
        push(16'($urandom), 4'($urandom), 12'($urandom_range(0, 3)));
      rd_chk("rnd_stat_pre", R_STAT, stat_exp(2'd0));
      if (m_ovf) begin
        wb_write(R_CTRL, 32'h8);
        m_ovf = 1'b0;
      end
      wb_write(R_CTRL, 32'h1);
      expect_seq();
      rd_chk("rnd_stat_post", R_STAT, stat_exp(2'd0));
    end

    // Loop mode: two entries alternate, pushes refused while running
    wb_write(R_CTRL, 32'hC);
    wb_write(R_PUSH, {12'd1, 4'h3, 16'hAB51});
    wb_write(R_PUSH, {12'd1, 4'h4, 16'h1234});
    wb_write(R_CTRL, 32'h3);
    @(posedge clk); #1;
    chk("loop_lat", {25'd0, irq_o, io_out}, {25'd0, 1'b0, 2'b00, last_io, 16'h0000});
    for (int p = 0; p < 12; p++) begin
      ev = (((p / 2) % 2) == 0) ? {4'h3, 16'hAB51} : {4'h4, 16'h1234};
      @(posedge clk); #1;
      chk("loop_seq", {25'd0, irq_o, io_out}, {25'd0, 1'b0, 2'b00, ev, 16'h0000});
    end
    wb_write(R_PUSH, {12'd0, 4'h7, 16'h7777});
    wb_read(R_STAT, d);
    chk("loop_stat", 64'(d & 32'h0000_101F), 64'h1002);
    wb_write(R_CTRL, 32'h0);
    @(posedge clk); #1;
    rd_chk("loop_off_stat", R_STAT, 32'h1002);
    wb_write(R_CTRL, 32'hC);

    // Disable while holding an entry
    wb_write(R_PUSH, {12'd5, 4'h1, 16'h1111});
    wb_write(R_PUSH, {12'd5, 4'h2, 16'h2222});
    wb_write(R_PUSH, {12'd5, 4'h3, 16'h3333});
    wb_write(R_CTRL, 32'h1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (io_out[31:16] == 16'h1111) break;
    end
    chk("dis_seen", 64'(io_out[31:16]), 64'h1111);
    wb_write(R_CTRL, 32'h0);
    @(posedge clk); #1;
    rd_chk("dis_stat", R_STAT, 32'h0000_0002);
    chk("dis_io",  64'(io_out), {26'd0, 2'b00, 4'h1, 16'h1111, 16'h0000});
    chk("dis_oeb", 64'(io_oeb), 64'(OEB_OFF));
    wb_write(R_CTRL, 32'h4);

    // Asynchronous reset in the middle of a HOLD
    wb_write(R_PUSH, {12'd7, 4'h6, 16'hBEEF});
    wb_write(R_CTRL, 32'h1);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (io_out[31:16] == 16'hBEEF) break;
    end
    chk("hold_seen", 64'(io_out[31:16]), 64'hBEEF);
    #2 rst = 1'b1;
    #1;
    chk("arst_io",  64'(io_out), 64'd0);
    chk("arst_oeb", 64'(io_oeb), 64'(OEB_OFF));
    chk("arst_bus", {30'd0, bus.ack, irq_o, bus.dat_r}, 64'd0);
    @(posedge clk); #1;
    chk("arst_irq", 64'(irq_o), 64'd0);
    rst = 1'b0;
    q_model.delete();
    m_ovf = 1'b0;
    last_io = '0;
    rd_chk("arst_stat", R_STAT, 32'h0);
    rd_chk("arst_ctrl", R_CTRL, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_pattern_sequencer.md
GPIO_PATTERN_SEQUENCER -- requirements
Module: gpio_pattern_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, pattern FIFO entries (power of two, 2..16).
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous assert, active-high.
REQ-004 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i, input, 1 bit each: Wishbone slave cycle, strobe and write enable.
REQ-005 SHALL have port wbs_adr_i, input, 4 bits: byte address; bits [3:2] select a register.
REQ-006 SHALL have port wbs_dat_i, input, 32 bits: write data.
REQ-007 SHALL have port wbs_ack_o, output, 1 bit: transfer acknowledge.
REQ-008 SHALL have port wbs_dat_o, output, 32 bits: read data.
REQ-009 SHALL have port io_out, output, 38 bits: user IO drive values.
REQ-010 SHALL have port io_oeb, output, 38 bits: user IO output enables, active-low.
REQ-011 SHALL have port irq_o, output, 1 bit: sequence-done pulse.

Function
REQ-012 SHALL decode registers: 0x0 CTRL (R/W: bit0 enable, bit1 loop; W-only self-clearing: bit2 flush, bit3 clear_ovf); 0x4 PUSH (W: [15:0] checkbits, [19:16] status, [31:20] dwell); 0x8 STAT (R: [4:0] count, [9:8] state, bit12 overflow); 0xC reads 0, writes ignored.
REQ-013 SHALL assert wbs_ack_o for exactly one cycle, the cycle after cyc&stb is seen with ack low; ack is low in the following cycle; the write takes effect at the ack edge.
REQ-014 SHALL present wbs_dat_o registered, valid while ack is high, and zero otherwise.
REQ-015 SHALL accept a PUSH when count<DEPTH; a PUSH at count==DEPTH is dropped and sets sticky overflow, even if a pop occurs in the same cycle.
REQ-016 SHALL drop a PUSH, and set overflow, while loop=1 and state!=IDLE.
REQ-017 SHALL implement FSM IDLE(0), LOAD(1), HOLD(2), DONE(3).
REQ-018 IDLE->LOAD when enable=1 and count>0; otherwise it stays in IDLE.
REQ-019 LOAD: pop head entry; on the same edge io_out[31:16]<=checkbits, io_out[35:32]<=status, dwell counter<=dwell; next state is HOLD if dwell>0, else LOAD if count after pop >0, else DONE.
REQ-020 HOLD: decrement counter each cycle; at 1->0, go to LOAD if count>0, else DONE.
REQ-021 Each entry's value SHALL remain on io_out for exactly dwell+1 cycles when another entry follows it.
REQ-022 DONE: irq_o high for exactly this one cycle; next state IDLE; io_out retains its last value.
REQ-023 In loop mode, a popped entry SHALL be rewritten at the FIFO tail in the same cycle; count is unchanged and the sequence repeats until enable=0.
REQ-024 Clearing enable in any state SHALL force IDLE on the next edge; the entry being held is discarded, io_out holds, and the FIFO is preserved.
REQ-025 flush SHALL empty the FIFO and force IDLE on the next edge; it takes priority over a simultaneous pop or loop rewrite.
REQ-026 io_oeb[35:16] SHALL equal ~enable, with all other io_oeb bits 1; io_out[15:0] and io_out[37:36] SHALL be 0.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.

Reset
REQ-028 While wb_rst_i=1: state IDLE, FIFO empty, enable=loop=overflow=0, io_out=0, io_oeb all 1, wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
REQ-029 Reset asserted mid-operation SHALL abort immediately, with no irq_o pulse.

Verification
REQ-030 Push {AB40,a,dwell 3} then {0009,5,dwell 0}, then enable -> io_out[31:16]=AB40 for 4 cycles, then 0009 for 1 cycle; irq_o pulses once; io_out[35:32] shows a then 5.
REQ-031 Push 8 entries, push a 9th -> STAT count=8 and overflow=1; clear_ovf -> overflow=0.
REQ-032 Loop=1 with 2 entries {AB51,dwell 1} and {1234,dwell 1} -> values alternate every 2 cycles for at least 3 periods; count stays 2; no irq_o.
REQ-033 Clear enable during HOLD -> state IDLE next cycle; io_out holds; count reduced only by entries already popped.
REQ-034 Flush in the same cycle as a LOAD pop -> count=0, IDLE, no irq_o.
REQ-035 Assert wb_rst_i mid-HOLD -> all outputs at reset values asynchronously; after release, STAT reads 0.
